// File: rtl/sliding_window_gen.sv
// KxK sliding-window generator: K-1 line delays feed a KxK tap array, raster-order input.
// Optional Frame_Done output is built only when SWG_FRAME_DONE_EN is defined.
module sliding_window_gen #(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = 8,
  parameter int K          = 3
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic [Datawidth-1:0]         In,
  input  logic                         Valid_IN,
  input  logic                         Frame_Start,
  output logic [K*K*Datawidth-1:0]     Window,
  output logic                         Valid_OUT
`ifdef SWG_FRAME_DONE_EN
  ,
  output logic                         Frame_Done
`endif
);

  localparam int CW = $clog2(IMG_Width);
  localparam int RW = $clog2(IMG_Height);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          vld_q, vld_d;

  logic [Datawidth-1:0] lb_q   [K-1][IMG_Width];
  logic [Datawidth-1:0] lb_d   [K-1][IMG_Width];
  logic [Datawidth-1:0] win_q  [K][K];
  logic [Datawidth-1:0] win_d  [K][K];
  logic [Datawidth-1:0] row_in [K];

  // Position of the pixel being accepted this cycle; Frame_Start forces it to (0,0).
  always_comb begin
    pos_col = col_q;
    pos_row = row_q;
    if (Frame_Start) begin
      pos_col = '0;
      pos_row = '0;
    end
    col_d = col_q;
    row_d = row_q;
    vld_d = 1'b0;
    if (Valid_IN) begin
      vld_d = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end else if (Frame_Start) begin
      col_d = '0;
      row_d = '0;
    end
  end

  // Window row K-1 takes the live pixel; row K-2-j takes the output of line delay j.
  always_comb begin
    lb_d  = lb_q;
    win_d = win_q;
    row_in[K-1] = In;
    for (int j = 0; j < K-1; j++) begin
      row_in[K-2-j] = lb_q[j][IMG_Width-1];
    end
    if (Valid_IN) begin
      lb_d[0][0] = In;
      for (int j = 1; j < K-1; j++) begin
        lb_d[j][0] = lb_q[j-1][IMG_Width-1];
      end
      for (int j = 0; j < K-1; j++) begin
        for (int i = 1; i < IMG_Width; i++) begin
          lb_d[j][i] = lb_q[j][i-1];
        end
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = row_in[r];
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      col_q <= '0;
      row_q <= '0;
      vld_q <= 1'b0;
      lb_q  <= '{default: '0};
      win_q <= '{default: '0};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= vld_d;
      lb_q  <= lb_d;
      win_q <= win_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign Window[(r*K+c)*Datawidth +: Datawidth] = win_q[r][c];
    end
  end

  assign Valid_OUT = vld_q;

`ifdef SWG_FRAME_DONE_EN
  logic fd_q, fd_d;

  always_comb begin
    fd_d = Valid_IN && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) fd_q <= 1'b0;
    else      fd_q <= fd_d;
  end

  assign Frame_Done = fd_q;
`endif

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen: K=3 and K=7 instances on an 8x8 image share one stream.
// Frame_Done checks are compiled in when SWG_FRAME_DONE_EN is defined.
module tb_sliding_window_gen;

  logic         CLK;
  logic         CLR;
  logic [7:0]   In;
  logic         Valid_IN;
  logic         Frame_Start;
  logic [71:0]  win3;
  logic [391:0] win7;
  logic         vo3, vo7;
`ifdef SWG_FRAME_DONE_EN
  logic         fd3, fd7;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n3, n7, first3, first7;
  logic [71:0]  snap3;
  logic [391:0] snap7;

  sliding_window_gen #(.IMG_Width(8), .IMG_Height(8), .Datawidth(8), .K(3)) dut3 (
    .CLK(CLK), .CLR(CLR), .In(In), .Valid_IN(Valid_IN), .Frame_Start(Frame_Start),
    .Window(win3), .Valid_OUT(vo3)
`ifdef SWG_FRAME_DONE_EN
    , .Frame_Done(fd3)
`endif
  );

  sliding_window_gen #(.IMG_Width(8), .IMG_Height(8), .Datawidth(8), .K(7)) dut7 (
    .CLK(CLK), .CLR(CLR), .In(In), .Valid_IN(Valid_IN), .Frame_Start(Frame_Start),
    .Window(win7), .Valid_OUT(vo7)
`ifdef SWG_FRAME_DONE_EN
    , .Frame_Done(fd7)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] t3(input int r, input int c);
    return win3[(r*3+c)*8 +: 8];
  endfunction

  function automatic logic [7:0] t7(input int r, input int c);
    return win7[(r*7+c)*8 +: 8];
  endfunction

  task automatic clear_stats();
    n3 = 0; n7 = 0; first3 = -1; first7 = -1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0; Valid_IN = 1'b0; Frame_Start = 1'b0; In = '0;
    #1;
    chk("rst_vout3", vo3, 1'b0);
    chk("rst_vout7", vo7, 1'b0);
    chk("rst_win3", win3, '0);
    chk("rst_win7", win7, '0);
`ifdef SWG_FRAME_DONE_EN
    chk("rst_fdone3", fd3, 1'b0);
`endif
    @(negedge CLK);
    CLR = 1'b1;
    clear_stats();
  endtask

  // q is the frame position the pixel should occupy (row = q/8, col = q%8).
  task automatic push(input int q, input logic [7:0] v, input logic fs);
    logic e3, e7;
    @(negedge CLK);
    In = v; Valid_IN = 1'b1; Frame_Start = fs;
    @(posedge CLK);
    #1;
    e3 = (q / 8 >= 2) && (q % 8 >= 2);
    e7 = (q / 8 >= 6) && (q % 8 >= 6);
    chk("vout3", vo3, e3);
    chk("vout7", vo7, e7);
    if (vo3) begin
      n3++;
      if (first3 < 0) first3 = q;
      chk("tap22_k3", t3(2,2), v);
      chk("tap11_k3", t3(1,1), 8'(v - 9));
      chk("tap00_k3", t3(0,0), 8'(v - 18));
    end
    if (vo7) begin
      n7++;
      if (first7 < 0) first7 = q;
      chk("tap66_k7", t7(6,6), v);
      chk("tap33_k7", t7(3,3), 8'(v - 27));
      chk("tap00_k7", t7(0,0), 8'(v - 54));
    end
`ifdef SWG_FRAME_DONE_EN
    chk("fdone3", fd3, (q == 63));
    chk("fdone7", fd7, (q == 63));
`endif
  endtask

  task automatic idle(input logic fs);
    @(negedge CLK);
    Valid_IN = 1'b0; Frame_Start = fs;
    @(posedge CLK);
    #1;
    chk("idle_vout3", vo3, 1'b0);
    chk("idle_vout7", vo7, 1'b0);
  endtask

  task automatic frame_totals(input string tag);
    chk({tag, "_first3"}, 32'(first3), 32'd18);
    chk({tag, "_count3"}, 32'(n3), 32'd36);
    chk({tag, "_first7"}, 32'(first7), 32'd54);
    chk({tag, "_count7"}, 32'(n7), 32'd4);
  endtask

  initial begin
    CLR = 1'b1; Valid_IN = 1'b0; Frame_Start = 1'b0; In = '0;
    clear_stats();

    // Continuous frame, In = row*8+col
    do_reset();
    for (int q = 0; q < 64; q++) push(q, 8'(q), 1'b0);
    frame_totals("cont");

    // Valid_IN toggling 1,0
    do_reset();
    for (int q = 0; q < 64; q++) begin
      push(q, 8'(q), 1'b0);
      snap3 = win3;
      snap7 = win7;
      idle(1'b0);
      chk("hold_win3", win3, snap3);
      chk("hold_win7", win7, snap7);
    end
    frame_totals("toggle");

    // Asynchronous reset mid-frame after pixel 30
    do_reset();
    for (int q = 0; q <= 30; q++) push(q, 8'(q), 1'b0);
    #2;
    CLR = 1'b0; Valid_IN = 1'b0;
    #1;
    chk("async_vout3", vo3, 1'b0);
    chk("async_vout7", vo7, 1'b0);
    chk("async_win3", win3, '0);
    chk("async_win7", win7, '0);
    @(negedge CLK);
    CLR = 1'b1;
    clear_stats();
    for (int q = 0; q < 64; q++) push(q, 8'(q), 1'b0);
    frame_totals("postrst");

    // Frame_Start with Valid_IN at pixel 13, new frame values 100+q
    do_reset();
    for (int q = 0; q < 13; q++) push(q, 8'(q), 1'b0);
    for (int q = 0; q < 64; q++) push(q, 8'(100 + q), (q == 0));
    frame_totals("resync");

    // Frame_Start with Valid_IN low: counters cleared, no data pushed
    do_reset();
    for (int q = 0; q < 5; q++) push(q, 8'(q), 1'b0);
    idle(1'b1);
    for (int q = 0; q < 64; q++) push(q, 8'(q), 1'b0);
    frame_totals("idle_fs");

    @(negedge CLK);
    Valid_IN = 1'b0; Frame_Start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
